// File: rtl/turbo_encoder_tx.sv
// turbo_encoder_tx: rate-1/3 turbo encoder with serial triplet output.
// Two RSC constituent encoders (feedback 1+D+D^2, feedforward 1+D^2).
// The first sees the natural bit order and the second sees the interleaved order.
// Each bit index t is sent as three serial bits: systematic, parity1, parity2.
// Optional build macro TURBO_ENC_BLKCNT_EN adds a 16-bit completed-frame counter port.

// One RSC constituent encoder lane. Parity is combinational from the current state and input.
module turbo_encoder_tx_rsc (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic adv,
  input  logic x,
  output logic p
);
  logic s1, s2, a;

  assign a = x ^ s1 ^ s2;
  assign p = a ^ s2;

  // The state is cleared at each frame start. It advances once per bit index, after parity2 is sent.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (adv) begin
      s1 <= a;
      s2 <= s1;
    end
  end
endmodule

module turbo_encoder_tx #(
  parameter int K       = 8,
  parameter int INTLV_A = 3,
  parameter int INTLV_B = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [K-1:0] data_in,
  input  logic         data_valid,
  output logic         ready,
  output logic         op,
  output logic         op_valid,
  output logic         frame_start
`ifdef TURBO_ENC_BLKCNT_EN
  , output logic [15:0] blk_count
`endif
);
  localparam int TW = $clog2(K);
  localparam int NUM_ENC = 2;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  generate
    if (K < 4 || K > 128 || (K & (K - 1)) != 0) begin : g_bad_k
      $error("turbo_encoder_tx: K must be a power of two in 4..128");
    end
    if ((INTLV_A % 2) == 0) begin : g_bad_a
      $error("turbo_encoder_tx: INTLV_A must be odd");
    end
    if (INTLV_B < 0 || INTLV_B >= K) begin : g_bad_b
      $error("turbo_encoder_tx: INTLV_B must be in 0..K-1");
    end
  endgenerate

  logic [0:0]         state;
  logic [TW-1:0]      t;
  logic [TW-1:0]      t_nxt;
  logic [1:0]         phase;
  logic [K-1:0]       blk;
  logic [TW-1:0]      pi_t;
  logic               last_bit;
  logic               accept;
  logic               enc_adv;
  logic [NUM_ENC-1:0] enc_x;
  logic [NUM_ENC-1:0] enc_p;

  // The last serial bit of the frame is the only SEND cycle that can take a new block.
  assign last_bit = (state == SEND) && (t == TW'(K - 1)) && (phase == 2'd2);
  assign ready    = !rst && ((state == IDLE) || last_bit);
  assign accept   = data_valid && ready;
  assign t_nxt    = t + TW'(1);

  // K is a power of two, so the modulo reduces to keeping the low TW bits.
  assign pi_t = TW'(INTLV_A * int'(t) + INTLV_B);

  // u[t] = blk[K-1-t]. With a power-of-two K, K-1-t is simply ~t in TW bits.
  assign enc_x[0] = blk[~t];
  assign enc_x[1] = blk[~pi_t];
  assign enc_adv  = (state == SEND) && (phase == 2'd2);

  generate
    for (genvar g = 0; g < NUM_ENC; g++) begin : g_enc
      turbo_encoder_tx_rsc u_rsc (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .adv (enc_adv),
        .x   (enc_x[g]),
        .p   (enc_p[g])
      );
    end
  endgenerate

  // Sequencer: counters and the block latch track the bit currently on op.
  // op is loaded with the bit for the next position.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      t           <= '0;
      phase       <= 2'd0;
      blk         <= '0;
      op          <= 1'b0;
      op_valid    <= 1'b0;
      frame_start <= 1'b0;
    end else if (accept) begin
      state       <= SEND;
      t           <= '0;
      phase       <= 2'd0;
      blk         <= data_in;
      op          <= data_in[K-1];
      op_valid    <= 1'b1;
      frame_start <= 1'b1;
    end else if (state == SEND) begin
      frame_start <= 1'b0;
      if (last_bit) begin
        state    <= IDLE;
        t        <= '0;
        phase    <= 2'd0;
        op       <= 1'b0;
        op_valid <= 1'b0;
      end else begin
        case (phase)
          2'd0: begin
            phase <= 2'd1;
            op    <= enc_p[0];
          end
          2'd1: begin
            phase <= 2'd2;
            op    <= enc_p[1];
          end
          default: begin
            phase <= 2'd0;
            t     <= t_nxt;
            op    <= blk[~t_nxt];
          end
        endcase
      end
    end
  end

`ifdef TURBO_ENC_BLKCNT_EN
  // Count frames whose final bit was sent. Reset aborts clear the counter rather than bump it.
  always_ff @(posedge clk) begin
    if (rst) blk_count <= 16'd0;
    else if (last_bit) blk_count <= blk_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_turbo_encoder_tx.sv
// Bench for turbo_encoder_tx (K=8, INTLV_A=3, INTLV_B=5).
// The driver pushes the expected {frame_start, op} pair for every serial bit.
// An independent monitor pops and compares the pairs whenever op_valid is high.
module tb_turbo_encoder_tx;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       ready;
  logic       op;
  logic       op_valid;
  logic       frame_start;
`ifdef TURBO_ENC_BLKCNT_EN
  logic [15:0] blk_count;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic [1:0] sb[$];

  always #5 clk = ~clk;

  turbo_encoder_tx #(.K(8), .INTLV_A(3), .INTLV_B(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .ready       (ready),
    .op          (op),
    .op_valid    (op_valid),
    .frame_start (frame_start)
`ifdef TURBO_ENC_BLKCNT_EN
    , .blk_count (blk_count)
`endif
  );

  // Monitor: every valid serial bit must match the head of the scoreboard.
  always @(negedge clk) begin
    if (op_valid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_bit got fs=%0b op=%0b, required none", frame_start, op);
      end else begin
        logic [1:0] e;
        e = sb.pop_front();
        if ({frame_start, op} !== e) begin
          n_bad++;
          $display("FAIL serial_bit got fs=%0b op=%0b, required fs=%0b op=%0b",
                   frame_start, op, e[1], e[0]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %0d, required %0d", name, act, exp);
    end
  endtask

  // Expected frame from hand-computed deserialized words (bit t sits at position 7-t).
  task automatic push_frame(input logic [7:0] s, input logic [7:0] p1, input logic [7:0] p2);
    for (int i = 0; i < 8; i++) begin
      sb.push_back({(i == 0), s[7-i]});
      sb.push_back({1'b0, p1[7-i]});
      sb.push_back({1'b0, p2[7-i]});
    end
  endtask

  // Offer d0 (and optionally d1 back-to-back). Report the op_valid run length
  // and the run cycle at which ready first reappeared.
  task automatic run_blocks(input logic [7:0] d0, input logic [7:0] d1, input bit two,
                            output int run, output int rdy_at);
    int guard;
    guard = 0;
    data_in = d0;
    data_valid = 1'b1;
    while (!ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
    if (two) data_in = d1;
    else data_valid = 1'b0;
    run = 0;
    rdy_at = -1;
    while (op_valid && run < 200) begin
      run++;
      if (ready && rdy_at < 0) rdy_at = run;
      else if (rdy_at >= 0) data_valid = 1'b0;
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int run, rdy_at;
    rst = 1'b1;
    data_in = '0;
    data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ready_in_reset", int'(ready), 0);
    rst = 1'b0;
    #1;
    chk("rst_ready", int'(ready), 1);
    chk("rst_op_valid", int'(op_valid), 0);
    chk("rst_op", int'(op), 0);
    chk("rst_frame_start", int'(frame_start), 0);
`ifdef TURBO_ENC_BLKCNT_EN
    chk("rst_blk_count", int'(blk_count), 0);
`endif
    @(posedge clk); #1;

    // All-zero block
    push_frame(8'h00, 8'h00, 8'h00);
    run_blocks(8'h00, 8'h00, 1'b0, run, rdy_at);
    chk("zero_len", run, 24);
    chk("zero_ready_at", rdy_at, 24);
    chk("zero_idle_ready", int'(ready), 1);

    // All-ones block
    push_frame(8'hFF, 8'hB6, 8'hB6);
    run_blocks(8'hFF, 8'h00, 1'b0, run, rdy_at);
    chk("ones_len", run, 24);

    // Single leading one: exercises pi(1) = 0
    push_frame(8'h80, 8'hED, 8'h76);
    run_blocks(8'h80, 8'h00, 1'b0, run, rdy_at);
    chk("x80_len", run, 24);

    // Single trailing one: pi(6) = 7 puts it into v[6]
    push_frame(8'h01, 8'h01, 8'h03);
    run_blocks(8'h01, 8'h00, 1'b0, run, rdy_at);
    chk("x01_len", run, 24);

    // Back-to-back with data_valid held high
    push_frame(8'hFF, 8'hB6, 8'hB6);
    push_frame(8'h80, 8'hED, 8'h76);
    run_blocks(8'hFF, 8'h80, 1'b1, run, rdy_at);
    chk("b2b_len", run, 48);
    chk("b2b_ready_at", rdy_at, 24);

    // Reset at cycle 10 of a frame
    push_frame(8'hFF, 8'hB6, 8'hB6);
    data_in = 8'hFF;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("abort_ready_in_rst", int'(ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_op_valid", int'(op_valid), 0);
    chk("abort_popped", sb.size(), 14);
    sb.delete();
    #1;
    chk("abort_ready", int'(ready), 1);
    @(posedge clk); #1;
    chk("abort_no_resume", int'(op_valid), 0);

    // After the abort, the encoder state must start clean
    push_frame(8'hFF, 8'hB6, 8'hB6);
    run_blocks(8'hFF, 8'h00, 1'b0, run, rdy_at);
    chk("post_abort_len", run, 24);
    push_frame(8'h01, 8'h01, 8'h03);
    run_blocks(8'h01, 8'h00, 1'b0, run, rdy_at);
    push_frame(8'h00, 8'h00, 8'h00);
    run_blocks(8'h00, 8'h00, 1'b0, run, rdy_at);
`ifdef TURBO_ENC_BLKCNT_EN
    chk("blk_count", int'(blk_count), 3);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    chk("final_op_valid", int'(op_valid), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/turbo_encoder_tx.md
Name: turbo_encoder_tx

Overview:
Rate-1/3 turbo encoder and serializer, the transmit end of the turbo link. Accepts one K-bit information block per handshake. Runs two identical RSC constituent encoders: one on the natural-order bits, one on the interleaved bits. Emits a continuous serial stream of triplets (systematic, parity1, parity2), one bit per clock, in the order the serial turbo decoder front-end deframes.

Parameters:
K, 8, information bits per block; power of two, 4..128; frame length is 3*K serial bits.
INTLV_A, 3, interleaver multiplier; must be odd.
INTLV_B, 5, interleaver offset; 0..K-1.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
data_in  in  K  information block; data_in[K-1] is transmitted first
data_valid  in  1  block offered
ready  out  1  block accepted when data_valid && ready
op  out  1  serial encoded bit
op_valid  out  1  op carries a frame bit
frame_start  out  1  high with the first bit (systematic, t=0) of each frame

Behaviour:
- Definitions:
  - u[t] = data_in[K-1-t], t = 0..K-1, latched at acceptance.
  - Interleaver: v[t] = u[pi(t)], with pi(t) = (INTLV_A*t + INTLV_B) mod K. K is a power of two, so mod is a truncation to log2(K) bits.
- RSC constituent encoder (feedback 1+D+D^2, feedforward 1+D^2):
  - State (s1,s2) cleared to (0,0) at each frame start.
  - Per bit x: a = x^s1^s2; p = a^s2; next s1 = a, s2 = s1.
  - No trellis termination or tail bits.
- ENC1 consumes u[t]. ENC2 consumes v[t].
- Frame order per t: phase 0 op = u[t]; phase 1 op = p1[t]; phase 2 op = p2[t]. Both encoder states advance at the end of phase 2.
- Counters: bit index t (log2 K bits) and phase (0..2).
- FSM:
  - IDLE: ready = 1, op_valid = 0. On accept: latch block, clear encoder states, go to SEND with t = 0, phase = 0.
  - SEND: op_valid = 1, one frame bit per cycle.
  - Last cycle (t = K-1, phase 2): ready = 1. If a block is accepted there, the next cycle is t = 0 of the new frame with frame_start = 1 and no gap; otherwise go to IDLE.
- Latency: first bit appears the cycle after the accepting edge. Frame occupies exactly 3*K consecutive cycles.
- ready is combinational from state and counters: 0 while rst is high, and 0 in SEND except the last cycle.
- data_in and data_valid are ignored while ready = 0. The latched block is stable for the whole frame.
- Reset values: op = 0, op_valid = 0, frame_start = 0, counters 0, encoder states 0, state IDLE.
- Reset mid-frame: the frame is aborted immediately. op_valid = 0 the cycle after, and no partial-frame resume.
- op, op_valid and frame_start are registered.

Optional Feature:
TURBO_ENC_BLKCNT_EN:
- Defined: adds output port blk_count [15:0], reset to 0, incremented on the last bit cycle of every completed frame. It wraps 0xFFFF -> 0. Aborted frames are not counted.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- data_in = 0x00, single accept -> 24 cycles op_valid = 1, all op = 0, frame_start only on cycle 1; then IDLE, ready = 1.
- data_in = 0xFF -> triplets 111,100,111,111,100,111,111,100. Deserialized: sys = 0xFF, par1 = 0xB6, par2 = 0xB6.
- data_in = 0x80 -> deserialized sys = 0x80, par1 = 0xED, par2 = 0x76. This checks the interleaver: pi(1) = 0.
- Blocks 0xFF then 0x80 with data_valid held high -> second accepted on cycle 24 of the first frame. 48 contiguous op_valid cycles, frame_start at cycles 1 and 25, with correct values for both frames.
- rst pulsed at cycle 10 of a frame -> op_valid = 0 the next cycle. A following accept of 0xFF reproduces the 0xFF vector exactly, proving encoder state was cleared.
- With TURBO_ENC_BLKCNT_EN, three full frames plus one aborted frame -> blk_count = 3.
